// File: rtl/window_regfile_pkg.sv
// window_regfile_pkg: shared defaults, logical register bases and the logical-to-physical mapping.
package window_regfile_pkg;
  localparam int NWIN_DEF = 4;
  localparam int DW_DEF = 32;
  localparam int GLOBALS = 8;
  localparam int G_BASE = 0;
  localparam int O_BASE = 8;
  localparam int L_BASE = 16;
  localparam int I_BASE = 24;
  typedef enum logic [1:0] {CWP_HOLD, CWP_LOAD, CWP_DEC, CWP_INC} cwp_op_e;
  // Physical layout: 8 globals, then per window 8 locals followed by 8 ins; outs alias the ins of window w-1.
  function automatic int phys_idx(input int r, input int w, input int nwin);
    return r < O_BASE ? r - G_BASE :
           r < L_BASE ? GLOBALS + ((w + nwin - 1) % nwin) * 16 + (I_BASE - L_BASE) + r - O_BASE :
           GLOBALS + w * 16 + r - L_BASE;
  endfunction
endpackage

// File: rtl/window_addr_map.sv
// window_addr_map: combinational mapper from logical register and window to physical index.
module window_addr_map
  import window_regfile_pkg::*;
#(
  parameter int NWIN = NWIN_DEF,
  parameter int CW = 5,
  parameter int PW = 7
) (
  input  logic [4:0]    r_i,
  input  logic [CW-1:0] cwp_i,
  output logic [PW-1:0] idx_o
);
  assign idx_o = PW'(phys_idx(int'(r_i), int'(cwp_i), NWIN));
endmodule

// File: rtl/window_regfile.sv
// window_regfile: windowed register file with CWP/WIM control and overflow/underflow pulses.
module window_regfile
  import window_regfile_pkg::*;
#(
  parameter int NWIN = NWIN_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 5
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [4:0]      RA,
  input  logic [4:0]      RB,
  input  logic [4:0]      RC,
  input  logic [DW-1:0]   Rin,
  input  logic            RFE,
  input  logic            SAVE,
  input  logic            RESTORE,
  input  logic            TRAP,
  input  logic            CWPE,
  input  logic [CW-1:0]   CWP_IN,
  input  logic            WIME,
  input  logic [NWIN-1:0] WIM_IN,
  output logic [DW-1:0]   Aout,
  output logic [DW-1:0]   Bout,
  output logic [CW-1:0]   CWP,
  output logic [NWIN-1:0] WIM,
  output logic            WOVF,
  output logic            WUNF
);
  localparam int NPHYS = GLOBALS + NWIN * 16;
  localparam int PW = $clog2(NPHYS);
  localparam logic [CW:0] NW_C = (CW+1)'(NWIN);
  localparam logic [CW-1:0] LAST = CW'(NWIN - 1);
  logic [DW-1:0] mem_q [NPHYS];
  logic [PW-1:0] a_idx, b_idx, c_idx;
  logic [CW-1:0] cwp_q, cwp_d, cwp_dec, cwp_inc;
  logic [NWIN-1:0] wim_q, wim_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wim_dec, wim_inc, cwpe_ok, sv, rs;
  cwp_op_e op;
  window_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_a (.r_i(RA), .cwp_i(cwp_q), .idx_o(a_idx));
  window_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_b (.r_i(RB), .cwp_i(cwp_q), .idx_o(b_idx));
  window_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_c (.r_i(RC), .cwp_i(cwp_q), .idx_o(c_idx));
  assign Aout = RA == '0 ? '0 : mem_q[a_idx];
  assign Bout = RB == '0 ? '0 : mem_q[b_idx];
  // Contents are deliberately unreset; r0 is masked on read instead of stored.
  always_ff @(posedge Clk)
    if (RFE && RC != '0) mem_q[c_idx] <= Rin;
  always_comb begin
    cwp_dec = cwp_q == '0 ? LAST : cwp_q - 1'b1;
    cwp_inc = cwp_q == LAST ? '0 : cwp_q + 1'b1;
    wim_dec = |(wim_q & (NWIN'(1) << cwp_dec));
    wim_inc = |(wim_q & (NWIN'(1) << cwp_inc));
    cwpe_ok = CWPE && {1'b0, CWP_IN} < NW_C;
    sv = SAVE & ~RESTORE;
    rs = RESTORE & ~SAVE;
    op = cwpe_ok ? CWP_LOAD : CWPE ? CWP_HOLD : (TRAP | (sv & ~wim_dec)) ? CWP_DEC :
         (rs & ~wim_inc) ? CWP_INC : CWP_HOLD;
    cwp_d = op == CWP_LOAD ? CWP_IN : op == CWP_DEC ? cwp_dec : op == CWP_INC ? cwp_inc : cwp_q;
    wim_d = WIME ? WIM_IN : wim_q;
    ovf_d = ~CWPE & ~TRAP & sv & wim_dec;
    unf_d = ~CWPE & ~TRAP & rs & wim_inc;
  end
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign CWP = cwp_q;
  assign WIM = wim_q;
  assign WOVF = ovf_q;
  assign WUNF = unf_q;
endmodule

// File: tb/tb_window_regfile.sv
// tb_window_regfile: directed checks of window_regfile with NWIN=4, DW=32, CW=5.
module tb_window_regfile;
  logic Clk = 0, Clr = 1;
  logic [4:0] RA = 0, RB = 0, RC = 0;
  logic [31:0] Rin = 0;
  logic RFE = 0, SAVE = 0, RESTORE = 0, TRAP = 0, CWPE = 0, WIME = 0;
  logic [4:0] CWP_IN = 0;
  logic [3:0] WIM_IN = 0;
  logic [31:0] Aout, Bout;
  logic [4:0] CWP;
  logic [3:0] WIM;
  logic WOVF, WUNF;
  int total = 0, bad = 0;

  window_regfile #(.NWIN(4), .DW(32), .CW(5)) dut (
    .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RC(RC), .Rin(Rin), .RFE(RFE),
    .SAVE(SAVE), .RESTORE(RESTORE), .TRAP(TRAP), .CWPE(CWPE), .CWP_IN(CWP_IN),
    .WIME(WIME), .WIM_IN(WIM_IN), .Aout(Aout), .Bout(Bout), .CWP(CWP), .WIM(WIM),
    .WOVF(WOVF), .WUNF(WUNF)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
    RFE = 0; SAVE = 0; RESTORE = 0; TRAP = 0; CWPE = 0; WIME = 0;
  endtask

  task automatic set_cwp(input logic [4:0] v);
    CWPE = 1; CWP_IN = v;
    tick();
  endtask

  task automatic set_wim(input logic [3:0] v);
    WIME = 1; WIM_IN = v;
    tick();
  endtask

  task automatic test_reset();
    #12;
    total++; if (CWP !== 5'd0) begin bad++; $display("FAIL reset_cwp got=%0d exp=0", CWP); end
    total++; if (WIM !== 4'd0) begin bad++; $display("FAIL reset_wim got=%b exp=0000", WIM); end
    total++; if (WOVF !== 1'b0 || WUNF !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", WOVF, WUNF); end
    Clr = 0;
    tick();
  endtask

  task automatic test_rw();
    RC = 17; Rin = 32'hDEADBEEF; RFE = 1;
    tick();
    RA = 17; #1;
    total++; if (Aout !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_r17 got=%h exp=deadbeef", Aout); end
    RC = 0; Rin = 5; RFE = 1;
    tick();
    RB = 0; #1;
    total++; if (Bout !== 32'h0) begin bad++; $display("FAIL rw_r0 got=%h exp=0", Bout); end
    RC = 17; Rin = 32'h12345678; RFE = 1; RA = 17; #1;
    total++; if (Aout !== 32'hDEADBEEF) begin bad++; $display("FAIL no_bypass got=%h exp=deadbeef", Aout); end
    tick();
    total++; if (Aout !== 32'h12345678) begin bad++; $display("FAIL rw_update got=%h exp=12345678", Aout); end
  endtask

  task automatic test_save();
    RC = 8; Rin = 32'h11; RFE = 1;
    tick();
    SAVE = 1;
    tick();
    RA = 24; #1;
    total++; if (CWP !== 5'd3) begin bad++; $display("FAIL save_wrap got=%0d exp=3", CWP); end
    total++; if (Aout !== 32'h11) begin bad++; $display("FAIL save_outs_ins got=%h exp=11", Aout); end
    total++; if (WOVF !== 1'b0) begin bad++; $display("FAIL save_no_ovf got=%b exp=0", WOVF); end
    RESTORE = 1;
    tick();
    total++; if (CWP !== 5'd0) begin bad++; $display("FAIL restore_wrap got=%0d exp=0", CWP); end
  endtask

  task automatic test_overflow();
    set_cwp(2);
    set_wim(4'b0010);
    SAVE = 1;
    tick();
    total++; if (CWP !== 5'd2 || WOVF !== 1'b1) begin bad++; $display("FAIL ovf_set got cwp=%0d wovf=%b exp cwp=2 wovf=1", CWP, WOVF); end
    tick();
    total++; if (WOVF !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b exp=0", WOVF); end
  endtask

  task automatic test_underflow();
    set_cwp(3);
    set_wim(4'b0001);
    RESTORE = 1;
    tick();
    total++; if (CWP !== 5'd3 || WUNF !== 1'b1) begin bad++; $display("FAIL unf_set got cwp=%0d wunf=%b exp cwp=3 wunf=1", CWP, WUNF); end
    tick();
    total++; if (WUNF !== 1'b0) begin bad++; $display("FAIL unf_pulse got=%b exp=0", WUNF); end
    set_wim(4'b0000);
    RESTORE = 1;
    tick();
    total++; if (CWP !== 5'd0 || WIM !== 4'b0000) begin bad++; $display("FAIL restore_ok got cwp=%0d wim=%b exp cwp=0 wim=0000", CWP, WIM); end
    SAVE = 1; RESTORE = 1;
    tick();
    total++; if (CWP !== 5'd0 || WOVF !== 1'b0 || WUNF !== 1'b0) begin bad++; $display("FAIL save_restore got cwp=%0d flags=%b%b exp cwp=0 flags=00", CWP, WOVF, WUNF); end
  endtask

  task automatic test_priority();
    CWPE = 1; CWP_IN = 1; TRAP = 1; SAVE = 1;
    tick();
    total++; if (CWP !== 5'd1 || WOVF !== 1'b0) begin bad++; $display("FAIL prio_cwpe got cwp=%0d wovf=%b exp cwp=1 wovf=0", CWP, WOVF); end
    CWPE = 1; CWP_IN = 7;
    tick();
    total++; if (CWP !== 5'd1) begin bad++; $display("FAIL cwpe_illegal got=%0d exp=1", CWP); end
    set_wim(4'b1111);
    TRAP = 1; SAVE = 1;
    tick();
    total++; if (CWP !== 5'd0 || WOVF !== 1'b0) begin bad++; $display("FAIL trap got cwp=%0d wovf=%b exp cwp=0 wovf=0", CWP, WOVF); end
    set_wim(4'b0000);
    WIME = 1; WIM_IN = 4'b1111; SAVE = 1;
    tick();
    total++; if (CWP !== 5'd3 || WOVF !== 1'b0 || WIM !== 4'b1111) begin bad++; $display("FAIL old_wim got cwp=%0d wovf=%b wim=%b exp cwp=3 wovf=0 wim=1111", CWP, WOVF, WIM); end
    set_wim(4'b0000);
  endtask

  task automatic test_global_save();
    RC = 5; Rin = 32'hA5; RFE = 1; SAVE = 1;
    tick();
    RA = 5; #1;
    total++; if (CWP !== 5'd2 || Aout !== 32'hA5) begin bad++; $display("FAIL global got cwp=%0d r5=%h exp cwp=2 r5=a5", CWP, Aout); end
    RC = 16; Rin = 32'h22; RFE = 1;
    tick();
    set_cwp(1);
    RA = 16; RB = 16; #1;
    RC = 16; Rin = 32'h33; RFE = 1;
    tick();
    set_cwp(2);
    #1;
    total++; if (Aout !== 32'h22) begin bad++; $display("FAIL local_isolation got=%h exp=22", Aout); end
  endtask

  task automatic test_async_reset();
    set_cwp(2);
    #2 Clr = 1;
    #1;
    total++; if (CWP !== 5'd0) begin bad++; $display("FAIL async_clr got=%0d exp=0", CWP); end
    Clr = 0;
    set_wim(4'b1000);
    SAVE = 1; Clr = 1;
    tick();
    total++; if (CWP !== 5'd0 || WOVF !== 1'b0 || WIM !== 4'b0000) begin bad++; $display("FAIL clr_over_save got cwp=%0d wovf=%b wim=%b exp cwp=0 wovf=0 wim=0000", CWP, WOVF, WIM); end
    Clr = 0;
  endtask

  initial begin
    test_reset();
    test_rw();
    test_save();
    test_overflow();
    test_underflow();
    test_priority();
    test_global_save();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
